move_piece_param: RTL and testbench

- Parametrised successor to the single-step piece mover. It holds the active piece (type, anchor, rotation) on a COLS x ROWS board.
- Each accepted step applies one lateral/rotate move and then one gravity fall. Every candidate position is checked against bounds and the locked-cell board.
- When the piece cannot fall, it is locked and a new piece is spawned. A blocked spawn raises game_over.
- Sits between the input/tick controller and the board-storage/line-clear block.

---
 rtl/move_piece_param.sv | 189 ++++++++++++++++++
 tb/tb_move_piece_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_piece_param.sv
// Active-piece mover for a COLS x ROWS board: one lateral/rotate move then one gravity fall per step,
// with lock, respawn and sticky game-over.
module move_piece_param #(
  parameter int COLS      = 4,
  parameter int ROWS      = 8,
  parameter int LOC_W     = 5,
  parameter int SPAWN_COL = 1,
  parameter int SPAWN_ROW = 1
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 step_valid,
  output logic                 step_ready,
  input  logic                 left,
  input  logic                 right,
  input  logic                 rotate,
  input  logic [1:0]           piece_type,
  input  logic [COLS*ROWS-1:0] locked_board,
  output logic [LOC_W-1:0]     piece_loc,
  output logic [1:0]           piece_rot,
  output logic [COLS*ROWS-1:0] piece_mask,
  output logic [COLS*ROWS-1:0] board_out,
  output logic                 lock_valid,
  output logic [COLS*ROWS-1:0] lock_mask,
  output logic                 game_over
);
  localparam int N     = COLS * ROWS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [2:0] {S_SPAWN, S_IDLE, S_LATERAL, S_FALL, S_LOCK, S_OVER} state_t;

  state_t           st;
  logic [1:0]       typ, rot;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             mv_left, mv_right, mv_rot;

  logic [1:0] cand_typ, cand_rot;
  int         cand_col, cand_row;
  logic       cand_ok;

  // Cell k (0..3) of a shape; unused cells repeat the anchor (0,0).
  function automatic void shape_off(input logic [1:0] t, input logic [1:0] r, input int k,
                                    output int dc, output int dr);
    dc = 0;
    dr = 0;
    case (t)
      2'b01: if (k == 1) begin
        if (r[0]) dc = 1;
        else      dr = -1;
      end
      2'b10: begin
        if (k == 1 || k == 3) dc = 1;
        if (k == 2 || k == 3) dr = -1;
      end
      2'b11: case (r)
        2'd0: begin if (k == 1) dc = 1; if (k == 2) dr = -1; end
        2'd1: begin if (k == 1) dr = -1; if (k == 2) begin dc = 1; dr = -1; end end
        2'd2: begin if (k == 1) begin dc = -1; dr = -1; end if (k == 2) dr = -1; end
        default: begin if (k == 1) dc = 1; if (k == 2) begin dc = 1; dr = -1; end end
      endcase
      default: ;
    endcase
  endfunction

  // Column and row are bounded separately so a col step never wraps into the next row.
  function automatic logic fits(input logic [1:0] t, input logic [1:0] r, input int c, input int rw,
                                input logic [N-1:0] board);
    int dc, dr, cc, rr;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      shape_off(t, r, k, dc, dr);
      cc = c + dc;
      rr = rw + dr;
      if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) ok = 1'b0;
      else if (|(board & (ONE << (rr * COLS + cc)))) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [N-1:0] cells(input logic [1:0] t, input logic [1:0] r, input int c, input int rw);
    int dc, dr, cc, rr;
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      shape_off(t, r, k, dc, dr);
      cc = c + dc;
      rr = rw + dr;
      if (cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) m = m | (ONE << (rr * COLS + cc));
    end
    return m;
  endfunction

  always_comb begin
    cand_typ = typ;
    cand_rot = rot;
    cand_col = int'(col);
    cand_row = int'(row);
    case (st)
      S_SPAWN: begin
        cand_typ = piece_type;
        cand_rot = 2'd0;
        cand_col = SPAWN_COL;
        cand_row = SPAWN_ROW;
      end
      S_LATERAL: begin
        if (mv_left)       cand_col = int'(col) - 1;
        else if (mv_right) cand_col = int'(col) + 1;
        else if (mv_rot) begin
          cand_rot = rot + 2'd1;
          // Type 11 kicks sideways on 1->2 and back on 2->3 to keep its footprint centred.
          if (typ == 2'b11 && rot == 2'd1)      cand_col = int'(col) + 1;
          else if (typ == 2'b11 && rot == 2'd2) cand_col = int'(col) - 1;
        end
      end
      S_FALL:  cand_row = int'(row) + 1;
      default: ;
    endcase
    cand_ok = fits(cand_typ, cand_rot, cand_col, cand_row, locked_board);
  end

  assign piece_mask = cells(typ, rot, int'(col), int'(row));
  assign board_out  = locked_board | piece_mask;
  assign piece_loc  = LOC_W'(int'(row) * COLS + int'(col));
  assign piece_rot  = rot;
  assign step_ready = (st == S_IDLE);

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      st         <= S_SPAWN;
      typ        <= 2'b00;
      rot        <= 2'd0;
      col        <= COL_W'(SPAWN_COL);
      row        <= ROW_W'(SPAWN_ROW);
      mv_left    <= 1'b0;
      mv_right   <= 1'b0;
      mv_rot     <= 1'b0;
      lock_valid <= 1'b0;
      lock_mask  <= '0;
      game_over  <= 1'b0;
    end else begin
      lock_valid <= 1'b0;
      lock_mask  <= '0;
      case (st)
        S_SPAWN: begin
          // The spawned piece is shown even when blocked, so OVER freezes it on the board.
          typ <= cand_typ;
          rot <= cand_rot;
          col <= COL_W'(cand_col);
          row <= ROW_W'(cand_row);
          if (cand_ok) st <= S_IDLE;
          else begin
            game_over <= 1'b1;
            st        <= S_OVER;
          end
        end
        S_IDLE: if (step_valid) begin
          mv_left  <= left;
          mv_right <= right;
          mv_rot   <= rotate;
          st       <= S_LATERAL;
        end
        S_LATERAL: begin
          if (cand_ok) begin
            rot <= cand_rot;
            col <= COL_W'(cand_col);
          end
          st <= S_FALL;
        end
        S_FALL: begin
          if (cand_ok) begin
            row <= ROW_W'(cand_row);
            st  <= S_IDLE;
          end else begin
            lock_valid <= 1'b1;
            lock_mask  <= piece_mask;
            st         <= S_LOCK;
          end
        end
        S_LOCK:  st <= S_SPAWN;
        S_OVER:  st <= S_OVER;
        default: st <= S_SPAWN;
      endcase
    end
  end
endmodule

// File: tb/tb_move_piece_param.sv
// Bench for move_piece_param: directed scenarios then random steps against a step-level board model.
module tb_move_piece_param;
  localparam int COLS = 4, ROWS = 8, LOC_W = 5, N = COLS * ROWS;

  logic             clka = 1'b0;
  logic             restart, step_valid, step_ready, left, right, rotate;
  logic [1:0]       piece_type;
  logic [N-1:0]     locked_board, piece_mask, board_out, lock_mask;
  logic [LOC_W-1:0] piece_loc;
  logic [1:0]       piece_rot;
  logic             lock_valid, game_over;

  move_piece_param #(.COLS(COLS), .ROWS(ROWS), .LOC_W(LOC_W), .SPAWN_COL(1), .SPAWN_ROW(1)) dut (
    .clka(clka), .restart(restart), .step_valid(step_valid), .step_ready(step_ready),
    .left(left), .right(right), .rotate(rotate), .piece_type(piece_type),
    .locked_board(locked_board), .piece_loc(piece_loc), .piece_rot(piece_rot),
    .piece_mask(piece_mask), .board_out(board_out), .lock_valid(lock_valid),
    .lock_mask(lock_mask), .game_over(game_over)
  );

  always #5 clka = ~clka;

  int errors = 0, checks = 0;
  int dc_tab[16][4], dr_tab[16][4];
  int m_typ, m_rot, m_col, m_row;
  bit m_go;

  task automatic set_shape(int idx, int c1, int r1, int c2, int r2, int c3, int r3);
    dc_tab[idx][0] = 0;  dr_tab[idx][0] = 0;
    dc_tab[idx][1] = c1; dr_tab[idx][1] = r1;
    dc_tab[idx][2] = c2; dr_tab[idx][2] = r2;
    dc_tab[idx][3] = c3; dr_tab[idx][3] = r3;
  endtask

  function automatic bit place(input int t, input int r, input int c, input int rw,
                               input logic [N-1:0] brd, output logic [N-1:0] m);
    bit ok;
    int cc, rr;
    ok = 1'b1;
    m  = '0;
    for (int k = 0; k < 4; k++) begin
      cc = c + dc_tab[t*4+r][k];
      rr = rw + dr_tab[t*4+r][k];
      if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) ok = 1'b0;
      else m = m | (N'(1) << (rr * COLS + cc));
    end
    if ((m & brd) != '0) ok = 1'b0;
    return ok;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic check_piece(string tag);
    logic [N-1:0] m;
    void'(place(m_typ, m_rot, m_col, m_row, '0, m));
    chk({tag, "_loc"},   piece_loc, m_row * COLS + m_col);
    chk({tag, "_rot"},   piece_rot, m_rot);
    chk({tag, "_mask"},  piece_mask, m);
    chk({tag, "_board"}, board_out, locked_board | m);
  endtask

  task automatic do_restart(logic [1:0] pt);
    restart = 1'b1; step_valid = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
    piece_type = pt;
    tick();
    chk("rst_ready", step_ready, 0);
    chk("rst_lockv", lock_valid, 0);
    chk("rst_lockm", lock_mask, 0);
    chk("rst_over",  game_over, 0);
    chk("rst_loc",   piece_loc, 5);
    locked_board = '0;
    restart = 1'b0;
    tick();
    tick();
    m_typ = pt; m_rot = 0; m_col = 1; m_row = 1; m_go = 1'b0;
    chk("spawn_ready", step_ready, 1);
    check_piece("spawn");
  endtask

  task automatic do_step(bit l, bit r, bit ro);
    int nc, nr;
    bit falls;
    logic [N-1:0] tmp, lockm;
    nc = m_col; nr = m_rot;
    if (l) nc--;
    else if (r) nc++;
    else if (ro) begin
      if (m_typ == 3 && m_rot == 1) nc++;
      else if (m_typ == 3 && m_rot == 2) nc--;
      nr = (m_rot + 1) % 4;
    end
    if (place(m_typ, nr, nc, m_row, locked_board, tmp)) begin
      m_col = nc; m_rot = nr;
    end
    falls = place(m_typ, m_rot, m_col, m_row + 1, locked_board, tmp);
    void'(place(m_typ, m_rot, m_col, m_row, '0, lockm));

    chk("pre_ready", step_ready, 1);
    step_valid = 1'b1; left = l; right = r; rotate = ro;
    tick();
    step_valid = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
    chk("busy_ready", step_ready, 0);
    tick();
    tick();
    if (falls) begin
      m_row++;
      chk("fall_ready", step_ready, 1);
      chk("fall_lockv", lock_valid, 0);
      check_piece("fall");
    end else begin
      chk("lock_valid", lock_valid, 1);
      chk("lock_mask",  lock_mask, lockm);
      chk("lock_ready", step_ready, 0);
      locked_board = locked_board | lockm;
      tick();
      chk("lock_pulse", lock_valid, 0);
      chk("lock_clear", lock_mask, 0);
      tick();
      m_typ = piece_type; m_rot = 0; m_col = 1; m_row = 1;
      if (place(m_typ, 0, 1, 1, locked_board, tmp)) begin
        chk("respawn_ready", step_ready, 1);
      end else begin
        m_go = 1'b1;
        chk("over_flag",  game_over, 1);
        chk("over_ready", step_ready, 0);
      end
      check_piece("respawn");
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      set_shape(0 + r, 0, 0, 0, 0, 0, 0);
      set_shape(8 + r, 1, 0, 0, -1, 1, -1);
    end
    set_shape(4, 0, -1, 0, 0, 0, 0);
    set_shape(6, 0, -1, 0, 0, 0, 0);
    set_shape(5, 1, 0, 0, 0, 0, 0);
    set_shape(7, 1, 0, 0, 0, 0, 0);
    set_shape(12, 1, 0, 0, -1, 0, 0);
    set_shape(13, 0, -1, 1, -1, 0, 0);
    set_shape(14, -1, -1, 0, -1, 0, 0);
    set_shape(15, 1, 0, 1, -1, 0, 0);
    locked_board = '0;

    // reset and left moves, including the left wall
    do_restart(2'b00);
    chk("init_mask", piece_mask, 32'h0000_0020);
    do_step(1, 0, 0);
    chk("left_loc", piece_loc, 8);
    do_step(1, 0, 0);
    chk("wall_loc", piece_loc, 12);

    // right wall must not wrap into the next row
    do_restart(2'b00);
    for (int i = 0; i < 5; i++) do_step(0, 1, 0);
    chk("edge_loc", piece_loc, 27);
    do_step(0, 1, 0);
    chk("nowrap_loc", piece_loc, 31);

    // fall to the bottom and lock
    do_restart(2'b00);
    for (int i = 0; i < 6; i++) do_step(0, 0, 0);
    chk("bottom_loc", piece_loc, 29);
    do_step(0, 0, 0);
    chk("relock_loc", piece_loc, 5);

    // blocked respawn -> game over, frozen while step_valid is held
    do_restart(2'b00);
    locked_board = 32'h0000_0200;
    do_step(0, 0, 0);
    chk("go_flag", game_over, 1);
    step_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("go_ready", step_ready, 0);
      chk("go_loc", piece_loc, 5);
    end
    step_valid = 1'b0;
    do_restart(2'b00);
    chk("go_cleared", game_over, 0);

    // type 11 rotate with kick, then the same rotate blocked
    do_restart(2'b11);
    do_step(0, 0, 1);
    do_step(0, 1, 0);
    chk("t11_rot1", piece_rot, 1);
    do_step(0, 0, 1);
    chk("t11_rot2", piece_rot, 2);
    chk("t11_loc",  piece_loc, 19);
    do_restart(2'b11);
    do_step(0, 0, 1);
    do_step(0, 1, 0);
    locked_board = 32'h0000_0400;
    do_step(0, 0, 1);
    chk("t11_blk_rot", piece_rot, 1);
    chk("t11_blk_loc", piece_loc, 18);

    // restart in the middle of a step: no lock pulse, back to spawn
    do_restart(2'b00);
    for (int i = 0; i < 6; i++) do_step(0, 0, 0);
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    tick();
    restart = 1'b1;
    #1;
    chk("abort_lockv", lock_valid, 0);
    chk("abort_loc",   piece_loc, 5);
    tick();
    chk("abort_lockv2", lock_valid, 0);
    restart = 1'b0;
    locked_board = '0;
    tick();
    tick();
    chk("abort_ready", step_ready, 1);

    // random play against the model
    do_restart(2'($urandom_range(0, 3)));
    for (int i = 0; i < 200; i++) begin
      if (m_go) do_restart(2'($urandom_range(0, 3)));
      else begin
        piece_type = 2'($urandom_range(0, 3));
        do_step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
